// File: rtl/timebase_pkg.sv
// Shared constants and state encoding for the stopwatch timebase controller.
package timebase_pkg;

  localparam int unsigned TICK_DIV_DEF  = 50_000_000;
  localparam int unsigned DB_CYCLES_DEF = 1_000_000;
  localparam int unsigned P_W           = 27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-FF synchronizer, stability debounce and press detect.
// A key held through reset is ignored until it has been seen released.
module key_debounce
  import timebase_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic [1:0]       warm_q;
  logic             level_q;
  logic             level_dly;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic             synced;

  assign synced = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      warm_q    <= 2'b00;
      level_q   <= 1'b1;
      level_dly <= 1'b1;
      armed     <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      warm_q    <= {warm_q[0], 1'b1};
      level_dly <= level_q;
      // Arm only once the synchronizer carries a real post-reset sample of a released key.
      if (warm_q[1] && synced && level_q) armed <= 1'b1;
      if (synced == level_q) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        level_q <= synced;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign press = ~level_q & level_dly & armed;

endmodule

// File: rtl/timebase_ctrl.sv
// Start/stop/clear control and 1 Hz count-enable generation for a stopwatch.
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic       tick,
  output logic       clear,
  output logic       running,
  output logic [1:0] state
);

  state_t         state_q;
  logic           running_q;
  logic [P_W-1:0] p;
  logic           start_press;
  logic           clear_press;
  logic           unused_start_level;
  logic           unused_clear_level;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_start_n),
    .level (unused_start_level),
    .press (start_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_clear_n),
    .level (unused_clear_level),
    .press (clear_press)
  );

  assign tick = (state_q == ST_RUN) && (p == P_W'(TICK_DIV - 1));

  // Clear overrides start; the prescaler holds outside RUN so a pause keeps the partial second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      p         <= '0;
    end else begin
      if (state_q == ST_RUN) p <= tick ? '0 : p + P_W'(1);
      if (clear_press) begin
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        p         <= '0;
      end else if (start_press) begin
        case (state_q)
          ST_IDLE, ST_PAUSE: begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
          ST_RUN: begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clear   = clear_press;
  assign running = running_q;
  assign state   = state_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Self-checking bench for timebase_ctrl: reference model, table of key actions, corner sequences.
module tb_timebase_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       clear_n = 1'b1;
  logic       tick;
  logic       clear;
  logic       running;
  logic [1:0] state;

  timebase_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_start_n (start_n),
    .key_clear_n (clear_n),
    .tick        (tick),
    .clear       (clear),
    .running     (running),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_tick = 0;
  int n_clr = 0;

  // Reference model: keys as sample histories, timer as cycles spent running.
  int          m_edge;
  int          m_st;
  int          m_run;
  logic [63:0] m_rawh [2];
  logic [63:0] m_win  [2];
  int          m_nv   [2];
  bit          m_d    [2];
  bit          m_dp   [2];
  bit          m_arm  [2];
  bit          m_press[2];

  function automatic void model_reset();
    m_edge = 0; m_st = 0; m_run = 0;
    for (int k = 0; k < 2; k++) begin
      m_rawh[k] = '1; m_win[k] = '1; m_nv[k] = 0;
      m_d[k] = 1'b1; m_dp[k] = 1'b1; m_arm[k] = 1'b0; m_press[k] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    bit syn, all_diff, arm_next, raw;
    if (m_press[1]) begin
      m_st = 0; m_run = 0;
    end else begin
      if (m_st == 1) m_run++;
      if (m_press[0]) m_st = (m_st == 1) ? 2 : 1;
    end
    m_edge++;
    for (int k = 0; k < 2; k++) begin
      raw = (k == 0) ? start_n : clear_n;
      syn = m_rawh[k][1];
      m_rawh[k] = {m_rawh[k][62:0], raw};
      arm_next = m_arm[k] | ((m_edge >= 3) && syn && m_d[k]);
      m_win[k] = {m_win[k][62:0], syn};
      if (m_nv[k] < DB) m_nv[k]++;
      all_diff = (m_nv[k] >= DB);
      for (int i = 0; i < DB; i++) if (m_win[k][i] == m_d[k]) all_diff = 1'b0;
      m_dp[k] = m_d[k];
      if (all_diff) m_d[k] = syn;
      m_arm[k] = arm_next;
      m_press[k] = !m_d[k] && m_dp[k] && m_arm[k];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    logic [4:0] exp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    exp = {2'(m_st), (m_st == 1), (m_st == 1) && (m_run % TD == TD - 1), m_press[1]};
    chk("model", {27'd0, state, running, tick, clear}, {27'd0, exp});
    if (tick === 1'b1) n_tick++;
    if (clear === 1'b1) n_clr++;
  endtask

  task automatic do_reset(input bit hold_start);
    start_n = !hold_start;
    clear_n = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1 chk("reset_async", {27'd0, state, running, tick, clear}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", {27'd0, state, running, tick, clear}, 32'd0);
    rst = 1'b1;
  endtask

  task automatic press(input bit s, input bit c);
    if (s) start_n = 1'b0;
    if (c) clear_n = 1'b0;
    repeat (DB + 6) cycle();
    start_n = 1'b1;
    clear_n = 1'b1;
    repeat (DB + 6) cycle();
  endtask

  typedef struct {
    bit         s;
    bit         c;
    logic [1:0] exp_state;
    bit         exp_running;
    int         exp_clears;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int c0, t0, k;

    tbl[0] = '{1, 0, 2'b01, 1, 0};
    tbl[1] = '{1, 0, 2'b10, 0, 0};
    tbl[2] = '{1, 0, 2'b01, 1, 0};
    tbl[3] = '{0, 1, 2'b00, 0, 1};
    tbl[4] = '{0, 1, 2'b00, 0, 1};
    tbl[5] = '{1, 0, 2'b01, 1, 0};
    tbl[6] = '{1, 1, 2'b00, 0, 1};
    tbl[7] = '{1, 0, 2'b01, 1, 0};
    tbl[8] = '{1, 0, 2'b10, 0, 0};
    tbl[9] = '{0, 1, 2'b00, 0, 1};

    do_reset(0);
    repeat (4) cycle();
    for (int i = 0; i < 10; i++) begin
      c0 = n_clr;
      press(tbl[i].s, tbl[i].c);
      chk("tbl_state", {30'd0, state}, {30'd0, tbl[i].exp_state});
      chk("tbl_running", {31'd0, running}, {31'd0, tbl[i].exp_running});
      chk("tbl_clears", n_clr - c0, tbl[i].exp_clears);
    end

    // Start held from edge 1: RUN at edge 7, ticks 10/20/30 cycles after entry.
    do_reset(0);
    repeat (4) cycle();
    start_n = 1'b0;
    for (int e = 1; e <= 36; e++) begin
      cycle();
      if (e == 6) chk("start_latency_pre", {30'd0, state}, 32'd0);
      if (e == 7) chk("start_latency", {30'd0, state}, 32'd1);
      chk("tick_period", {31'd0, tick}, {31'd0, (e >= 7) && ((e - 6) % TD == 0)});
    end
    start_n = 1'b1;
    repeat (12) cycle();
    chk("release_no_event", {30'd0, state}, 32'd1);

    // Pause with p at 6, then resume: next tick 3 cycles later.
    k = 0;
    while (tick !== 1'b1 && k < 3 * TD) begin cycle(); k++; end
    chk("tick_found", {31'd0, tick}, 32'd1);
    start_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (i == 6) chk("pause_pre", {30'd0, state}, 32'd1);
      if (i == 7) chk("pause_state", {30'd0, state}, 32'd2);
    end
    repeat (5) cycle();
    start_n = 1'b1;
    t0 = n_tick;
    repeat (15) cycle();
    chk("pause_no_tick", n_tick - t0, 0);
    chk("pause_hold", {30'd0, state}, 32'd2);
    start_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i == 7) chk("resume_state", {30'd0, state}, 32'd1);
      if (i >= 8) chk("resume_tick", {31'd0, tick}, {31'd0, i == 10});
    end
    start_n = 1'b1;
    repeat (12) cycle();

    // Clear while RUN.
    c0 = n_clr;
    clear_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      chk("clear_pulse", {31'd0, clear}, {31'd0, i == 6});
      if (i == 6) chk("clear_pre_state", {30'd0, state}, 32'd1);
      if (i == 7) begin
        chk("clear_state", {30'd0, state}, 32'd0);
        chk("clear_running", {31'd0, running}, 32'd0);
      end
    end
    repeat (5) cycle();
    clear_n = 1'b1;
    repeat (12) cycle();
    chk("clear_once", n_clr - c0, 1);
    start_n = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      cycle();
      chk("tick_after_clear", {31'd0, tick}, {31'd0, i == 16});
    end
    start_n = 1'b1;
    repeat (12) cycle();

    // Start and clear together while PAUSE.
    press(1, 0);
    chk("pre_both_state", {30'd0, state}, 32'd2);
    c0 = n_clr;
    start_n = 1'b0;
    clear_n = 1'b0;
    repeat (7) cycle();
    chk("both_state", {30'd0, state}, 32'd0);
    start_n = 1'b1;
    clear_n = 1'b1;
    repeat (12) cycle();
    chk("both_clear_once", n_clr - c0, 1);
    chk("both_idle", {30'd0, state}, 32'd0);

    // Bouncing start in PAUSE: no event, no tick.
    press(1, 0);
    press(1, 0);
    t0 = n_tick;
    for (int i = 0; i < 40; i++) begin
      start_n = ((i / 3) % 2) != 0;
      cycle();
    end
    start_n = 1'b1;
    repeat (12) cycle();
    chk("bounce_state", {30'd0, state}, 32'd2);
    chk("bounce_no_tick", n_tick - t0, 0);

    // Reset mid-RUN with start held.
    press(1, 0);
    chk("pre_rst_state", {30'd0, state}, 32'd1);
    start_n = 1'b0;
    repeat (3) cycle();
    do_reset(1);
    repeat (20) cycle();
    chk("held_through_reset", {30'd0, state}, 32'd0);
    start_n = 1'b1;
    repeat (12) cycle();
    chk("held_release", {30'd0, state}, 32'd0);
    start_n = 1'b0;
    repeat (7) cycle();
    chk("repress_after_reset", {30'd0, state}, 32'd1);
    start_n = 1'b1;
    repeat (12) cycle();

    // Random key activity against the model.
    begin
      int hs, hc;
      hs = 1; hc = 1;
      for (int i = 0; i < 3000; i++) begin
        if (i == 1500) begin
          do_reset(!start_n);
          hs = 1;
        end
        if (--hs <= 0) begin
          start_n = ~start_n;
          hs = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 40));
        end
        if (--hc <= 0) begin
          clear_n = ~clear_n;
          hc = clear_n ? int'($urandom_range(20, 200)) : int'($urandom_range(1, 15));
        end
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000: clk cycles per count tick (1 Hz at 50 MHz), legal range 2..2^27-1.
REQ-002 SHALL have parameter DB_CYCLES, default 1_000_000: cycles a key level must stay stable before it is accepted (20 ms), legal range 2..2^20.
REQ-003 SHALL have port clk, input, 1: the single system clock, 50 MHz.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port key_start_n, input, 1: raw start/stop pushbutton, asynchronous to clk, low = pressed.
REQ-006 SHALL have port key_clear_n, input, 1: raw clear pushbutton, asynchronous to clk, low = pressed.
REQ-007 SHALL have port tick, output, 1: one-cycle count-enable pulse for the downstream time counter.
REQ-008 SHALL have port clear, output, 1: one-cycle pulse that zeroes the downstream time counter.
REQ-009 SHALL have port running, output, 1: high while state is RUN.
REQ-010 SHALL have port state, output, 2: current FSM state, IDLE=00, RUN=01, PAUSE=10.

Function
REQ-011 SHALL pass each key through a 2-FF synchronizer before any other use.
REQ-012 SHALL debounce each key as follows: accepted level d; counter reset to 0 while the synced level equals d; counter increments while it differs; when it differs and count==DB_CYCLES-1, d takes the synced level and the counter returns to 0.
REQ-013 SHALL assert the press pulse combinationally for exactly one cycle, in the cycle after d falls 1->0 (d low, delayed d high); key release SHALL generate no event.
REQ-014 SHALL apply FSM transitions on the edge after a press pulse: IDLE+start->RUN, RUN+start->PAUSE, PAUSE+start->RUN.
REQ-015 SHALL go to IDLE on a clear press from any state; clear SHALL win over a start press in the same cycle.
REQ-016 SHALL drive clear combinationally equal to the clear press pulse, including when already in IDLE.
REQ-017 SHALL increment the 27-bit prescaler p only in RUN; p==TICK_DIV-1 SHALL wrap p to 0.
REQ-018 SHALL hold p in PAUSE, so the partial second is preserved, and SHALL zero p on the edge entering IDLE.
REQ-019 SHALL compute tick = (state==RUN) && (p==TICK_DIV-1), giving the first tick TICK_DIV cycles after entering RUN with p=0 and ticks every TICK_DIV cycles thereafter.
REQ-020 SHALL make a raw key change sampled at edge 1 update state at edge DB_CYCLES+3; a bounce shorter than DB_CYCLES cycles SHALL cause no event.

Reset
REQ-021 SHALL, while rst is low, force state=IDLE, p=0, all debounce counters=0, sync FFs and accepted levels=1 (released), tick=0, clear=0, running=0.
REQ-022 SHALL have a key held pressed through reset release produce no event until it is released and pressed again.

Structure
REQ-023 SHALL place the state encoding constants and the default TICK_DIV and DB_CYCLES values in the shared package timebase_pkg.
REQ-024 SHALL implement synchronizer, debounce and press detect in sub-module key_debounce (parameter DB_CYCLES, outputs level and press), instantiated once per key.

Verification (TICK_DIV=10, DB_CYCLES=4)
REQ-025 SHALL cover: start held low from edge 1 -> state 00->01 at edge 7; tick high on cycles 10, 20, 30 after entry.
REQ-026 SHALL cover: in RUN at p=6, start pressed -> state=10, p held at 6; second press -> state=01, next tick after 3 cycles.
REQ-027 SHALL cover: clear pressed while RUN -> clear high exactly 1 cycle, state=00, p=0, running=0.
REQ-028 SHALL cover: start and clear pressed in the same cycle while PAUSE -> state=00, one clear pulse.
REQ-029 SHALL cover: start toggling every 3 cycles for 40 cycles -> no state change, no tick.
REQ-030 SHALL cover: rst low mid-RUN with start held -> all outputs 0, state=00; after release no event until start is released and pressed again.
